// File: rtl/platform_pkg.sv
// Shared types and constants for the platformer sprite controllers.
package platform_pkg;

    typedef enum logic [1:0] {GROUND, RISE, FALL} move_state_t;

    localparam logic [3:0] DIR_LEFT  = 4'd3;
    localparam logic [3:0] DIR_IDLE  = 4'd4;
    localparam logic [3:0] DIR_RIGHT = 4'd5;

    localparam int VEL_W = 11;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame_clk level into the Clk domain and emits a
// one-cycle tick per rising edge, three Clk edges after the rise.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic sync_meta;
    logic sync_stable;
    logic sync_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            tick        <= 1'b0;
        end else begin
            sync_meta   <= frame_clk;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            tick        <= sync_stable & ~sync_prev;
        end
    end

endmodule

// File: rtl/platform_character.sv
// Platformer sprite controller: walk, gravity, jump FSM, clamping and walk animation.
// Define DOUBLE_JUMP_EN to allow one extra jump per airtime.
module platform_character
    import platform_pkg::*;
#(
    parameter int W           = 30,
    parameter int H           = 30,
    parameter int X_START     = 320,
    parameter int Y_START     = 240,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 640,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 480,
    parameter int X_STEP      = 1,
    parameter int JUMP_V      = 8,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 8,
    parameter int ANIM_FRAMES = 4,
    parameter int ANIM_DIV    = 8,
    parameter int ADDR_W      = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              left_key,
    input  logic              right_key,
    input  logic              jump_key,
    output logic              is_char,
    output logic [ADDR_W-1:0] char_address,
    output logic [3:0]        char_direction,
    output logic [1:0]        char_state
);

    localparam logic signed [11:0] XLO = 12'(X_MIN);
    localparam logic signed [11:0] XHI = 12'(X_MAX - W);
    localparam logic signed [11:0] YLO = 12'(Y_MIN);
    localparam logic signed [11:0] YHI = 12'(Y_MAX - H);
    localparam logic signed [VEL_W-1:0] JV   = VEL_W'(JUMP_V);
    localparam logic signed [VEL_W-1:0] GRAV = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] MAXF = VEL_W'(MAX_FALL);
    localparam int CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(ANIM_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(ANIM_FRAMES - 1);

    logic tick;

    frame_tick_sync u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    logic [9:0]              x, y;
    logic signed [VEL_W-1:0] vy;
    move_state_t             state;
    logic [3:0]              dir;
    logic [CNT_W-1:0]        anim_cnt;
    logic [FRAME_W-1:0]      frame;
    logic                    jump_prev;

    logic [9:0]              x_next, y_next;
    logic signed [VEL_W-1:0] vy_next, vy_grav;
    move_state_t             state_next;
    logic [3:0]              dir_next;
    logic [CNT_W-1:0]        anim_cnt_next;
    logic [FRAME_W-1:0]      frame_next;
    logic signed [11:0]      x_try, y_try, y_s;
    logic                    jump_edge, landing;
`ifdef DOUBLE_JUMP_EN
    logic                    air_jump_avail, air_jump_next;
`endif

    always_comb begin
        jump_edge = jump_key & ~jump_prev;

        dir_next = DIR_IDLE;
        x_try    = $signed({2'b00, x});
        if (left_key && !right_key) begin
            x_try    = x_try - 12'(X_STEP);
            dir_next = DIR_LEFT;
        end else if (right_key && !left_key) begin
            x_try    = x_try + 12'(X_STEP);
            dir_next = DIR_RIGHT;
        end
        if (x_try < XLO) begin
            x_try = XLO;
        end else if (x_try > XHI) begin
            x_try = XHI;
        end
        x_next = x_try[9:0];

        y_s        = $signed({2'b00, y});
        y_try      = y_s;
        vy_grav    = vy + GRAV;
        vy_next    = vy;
        state_next = state;
        landing    = 1'b0;
        case (state)
            GROUND: begin
                if (jump_edge) begin
                    vy_next    = -JV;
                    y_try      = y_s + 12'(vy_next);
                    state_next = RISE;
                end else if (y_s < YHI) begin
                    state_next = FALL;
                end
            end
            RISE: begin
                vy_next = vy_grav;
                y_try   = y_s + 12'(vy_next);
                if (!vy_next[VEL_W-1]) begin
                    state_next = FALL;
                end
            end
            FALL: begin
                vy_next = (vy_grav > MAXF) ? MAXF : vy_grav;
                y_try   = y_s + 12'(vy_next);
                if (y_try >= YHI) begin
                    y_try      = YHI;
                    vy_next    = '0;
                    state_next = GROUND;
                    landing    = 1'b1;
                end
            end
            default: state_next = FALL;
        endcase

`ifdef DOUBLE_JUMP_EN
        air_jump_next = air_jump_avail;
        if (landing) begin
            air_jump_next = 1'b1;
        end else if (state != GROUND && jump_edge && air_jump_avail) begin
            vy_next       = -JV;
            y_try         = y_s + 12'(vy_next);
            state_next    = RISE;
            air_jump_next = 1'b0;
        end
`endif

        // Ceiling bump ends the ascent immediately.
        if (state_next == RISE && y_try <= YLO) begin
            y_try      = YLO;
            vy_next    = '0;
            state_next = FALL;
        end
        if (y_try < YLO) begin
            y_try = YLO;
        end
        y_next = y_try[9:0];

        anim_cnt_next = '0;
        frame_next    = '0;
        if (state_next == GROUND && dir_next != DIR_IDLE) begin
            anim_cnt_next = anim_cnt + 1'b1;
            frame_next    = frame;
            if (anim_cnt == CNT_LAST) begin
                anim_cnt_next = '0;
                frame_next    = (frame == FRAME_LAST) ? '0 : frame + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x              <= 10'(X_START);
            y              <= 10'(Y_START);
            vy             <= '0;
            state          <= FALL;
            dir            <= DIR_IDLE;
            anim_cnt       <= '0;
            frame          <= '0;
            jump_prev      <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            air_jump_avail <= 1'b1;
`endif
        end else if (tick) begin
            x              <= x_next;
            y              <= y_next;
            vy             <= vy_next;
            state          <= state_next;
            dir            <= dir_next;
            anim_cnt       <= anim_cnt_next;
            frame          <= frame_next;
            jump_prev      <= jump_key;
`ifdef DOUBLE_JUMP_EN
            air_jump_avail <= air_jump_next;
`endif
        end
    end

    logic [9:0] px, py;

    always_comb begin
        px      = DrawX - x;
        py      = DrawY - y;
        is_char = (DrawX >= x) && (12'(DrawX) < 12'(x) + 12'(W)) &&
                  (DrawY >= y) && (12'(DrawY) < 12'(y) + 12'(H));
        char_address = is_char ?
            ADDR_W'(32'(frame) * 32'(W * H) + 32'(py) * 32'(W) + 32'(px)) : '0;
        char_direction = dir;
        char_state     = state;
    end

endmodule

// File: tb/tb_platform_character.sv
// Directed bench for platform_character; define DOUBLE_JUMP_EN to add the air-jump vectors.
module tb_platform_character;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY;
    logic        left_key, right_key, jump_key;
    logic        is_char;
    logic [11:0] char_address;
    logic [3:0]  char_direction;
    logic [1:0]  char_state;

    localparam int ST_GROUND = 0;
    localparam int ST_RISE   = 1;
    localparam int ST_FALL   = 2;

    int checks = 0;
    int errors = 0;

    platform_character dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .left_key       (left_key),
        .right_key      (right_key),
        .jump_key       (jump_key),
        .is_char        (is_char),
        .char_address   (char_address),
        .char_direction (char_direction),
        .char_state     (char_state)
    );

    always #10 Clk = ~Clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_tick();
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    // Pins the sprite box edges, ROM addressing, state and direction.
    task automatic check_at(input string tag, input int xe, input int ye, input int fe,
                            input int se, input int de);
        DrawX = 10'(xe); DrawY = 10'(ye); #1;
        check({tag, " hit"}, 32'(is_char), 1);
        check({tag, " addr"}, 32'(char_address), fe * 900);
        DrawX = 10'(xe + 5); DrawY = 10'(ye + 2); #1;
        check({tag, " addr_mid"}, 32'(char_address), fe * 900 + 65);
        DrawX = 10'(xe + 29); DrawY = 10'(ye + 29); #1;
        check({tag, " addr_far"}, 32'(char_address), fe * 900 + 899);
        DrawX = 10'(xe + 30); #1;
        check({tag, " miss_r"}, 32'(is_char), 0);
        check({tag, " addr_out"}, 32'(char_address), 0);
        DrawX = 10'(xe); DrawY = 10'(ye + 30); #1;
        check({tag, " miss_b"}, 32'(is_char), 0);
        if (xe > 0) begin
            DrawX = 10'(xe - 1); DrawY = 10'(ye); #1;
            check({tag, " miss_l"}, 32'(is_char), 0);
        end
        if (ye > 0) begin
            DrawX = 10'(xe); DrawY = 10'(ye - 1); #1;
            check({tag, " miss_t"}, 32'(is_char), 0);
        end
        check({tag, " state"}, 32'(char_state), 32'(se));
        check({tag, " dir"}, 32'(char_direction), 32'(de));
    endtask

    int yfall[8] = '{243, 246, 250, 255, 261, 268, 276, 284};
    int yjump[17] = '{442, 435, 429, 424, 420, 417, 415, 414, 414,
                      415, 417, 420, 424, 429, 435, 442, 450};
    int sjump[17] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    int xe;

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
        left_key = 1'b0; right_key = 1'b0; jump_key = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_at("reset", 320, 240, 0, ST_FALL, 4);
        @(posedge Clk);
        #1 Reset = 1'b0;

        // First tick latency: no update through the third edge, update on the fourth.
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        DrawX = 10'd320; DrawY = 10'd240; #1;
        check("latency hold", 32'(is_char), 1);
        @(posedge Clk);
        @(negedge Clk);
        DrawX = 10'd320; DrawY = 10'd240; #1;
        check("latency old_row", 32'(is_char), 0);
        DrawY = 10'd241; #1;
        check("latency new_row", 32'(is_char), 1);
        frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);

        for (int i = 0; i < 8; i++) begin
            do_tick();
            check_at($sformatf("fall t%0d", i + 2), 320, yfall[i], 0, ST_FALL, 4);
        end
        ticks(20);
        check_at("fall t29", 320, 444, 0, ST_FALL, 4);
        do_tick();
        check_at("land", 320, 450, 0, ST_GROUND, 4);
        do_tick();
        check_at("ground hold", 320, 450, 0, ST_GROUND, 4);

        // Jump held through the arc, re-pressed exactly on the landing tick.
        jump_key = 1'b1;
        for (int t = 0; t < 17; t++) begin
            if (t == 15) jump_key = 1'b0;
            if (t == 16) jump_key = 1'b1;
            do_tick();
            check_at($sformatf("jump t%0d", t + 1), 320, yjump[t], 0, sjump[t], 4);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_at($sformatf("held t%0d", i), 320, 450, 0, ST_GROUND, 4);
        end
        jump_key = 1'b0;
        do_tick();
        check_at("released", 320, 450, 0, ST_GROUND, 4);
        jump_key = 1'b1;
        do_tick();
        check_at("rejump", 320, 442, 0, ST_RISE, 4);
        jump_key = 1'b0;
        ticks(16);
        check_at("reland", 320, 450, 0, ST_GROUND, 4);

        // Reset in mid-air.
        jump_key = 1'b1;
        do_tick();
        jump_key = 1'b0;
        ticks(2);
        check_at("rise t3", 320, 429, 0, ST_RISE, 4);
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check_at("reset mid", 320, 240, 0, ST_FALL, 4);
        ticks(29);
        check_at("refall t29", 320, 444, 0, ST_FALL, 4);
        do_tick();
        check_at("reland2", 320, 450, 0, ST_GROUND, 4);

        // Walk right with animation.
        right_key = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            do_tick();
            check_at($sformatf("walk k%0d", k), 320 + k, 450, (k / 8) % 4, ST_GROUND, 5);
        end
        right_key = 1'b0;
        do_tick();
        check_at("walk stop", 352, 450, 0, ST_GROUND, 4);
        right_key = 1'b1;
        ticks(300);
        xe = (352 + 300 > 610) ? 610 : 352 + 300;
        check_at("clamp right", xe, 450, (300 / 8) % 4, ST_GROUND, 5);
        left_key = 1'b1;
        do_tick();
        check_at("both keys", 610, 450, 0, ST_GROUND, 4);
        do_tick();
        check_at("both keys2", 610, 450, 0, ST_GROUND, 4);
        right_key = 1'b0;
        ticks(620);
        check_at("clamp left", 0, 450, (620 / 8) % 4, ST_GROUND, 3);
        left_key = 1'b0;
        do_tick();
        check_at("idle left", 0, 450, 0, ST_GROUND, 4);

`ifdef DOUBLE_JUMP_EN
        jump_key = 1'b1;
        do_tick();
        jump_key = 1'b0;
        ticks(8);
        check_at("dj peak", 0, 414, 0, ST_FALL, 4);
        jump_key = 1'b1;
        do_tick();
        check_at("dj air jump", 0, 406, 0, ST_RISE, 4);
        jump_key = 1'b0;
        do_tick();
        check_at("dj rise", 0, 399, 0, ST_RISE, 4);
        jump_key = 1'b1;
        do_tick();
        check_at("dj third ignored", 0, 393, 0, ST_RISE, 4);
        jump_key = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
